// File: rtl/mips_pkg.sv
// Shared MIPS decode-stage definitions: register file geometry and the
// state encoding of the register dump engine.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // r0 is hard-wired to zero in the MIPS ISA
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_BUSY = 2'd1,
    DUMP_FIN  = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_dump_fsm.sv
// Dump engine control: walks an index over every register and offers one
// word per cycle on a valid/ready handshake, then pulses done once.
module reg_dump_fsm
  import mips_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dump_state_e state_q;
  dump_state_e state_d;
  logic        accept;

  assign accept = (state_q == DUMP_BUSY) && dump_ready;

  // State register; an asserted reset aborts any dump in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DUMP_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: start only sampled in IDLE, DONE always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      DUMP_IDLE: if (dump_start) state_d = DUMP_BUSY;
      DUMP_BUSY: if (accept && (dump_idx == LAST_IDX)) state_d = DUMP_FIN;
      DUMP_FIN:  state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
  end

  // Outputs decoded straight from the state so reset clears them at once
  always_comb begin
    dump_valid = (state_q == DUMP_BUSY);
    dump_done  = (state_q == DUMP_FIN);
  end

  // Index advances on each accepted word, parks at 0 outside a dump
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dump_idx <= '0;
    end else if (state_q == DUMP_BUSY) begin
      if (accept && (dump_idx != LAST_IDX)) dump_idx <= dump_idx + 1'b1;
    end else begin
      dump_idx <= '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: one synchronous write port, two
// combinational read ports with write-through forwarding, and a serial
// dump port that streams the stored contents for debug readout.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;

  assign wr_en = we && (waddr != ZERO);

  // Register array; r0 is never written so it always holds zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports forward same-cycle write-back so decode sees the newest value
  always_comb begin
    if (raddr1 == ZERO)                     rdata1 = '0;
    else if (wr_en && (waddr == raddr1))    rdata1 = wdata;
    else                                    rdata1 = mem[raddr1];
    if (raddr2 == ZERO)                     rdata2 = '0;
    else if (wr_en && (waddr == raddr2))    rdata2 = wdata;
    else                                    rdata2 = mem[raddr2];
  end

  // Dump port shows stored contents only; a write to the held index
  // becomes visible the cycle after it lands
  always_comb begin
    if (dump_idx == ZERO) dump_data = '0;
    else                  dump_data = mem[dump_idx];
  end

  reg_dump_fsm #(
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_done  (dump_done)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, forwarding, full dump,
// dump under backpressure with a concurrent write, and reset mid-dump.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [32];
  logic [3:0]  rdy_pat = 4'b1001; // bit c%4 gives ready: 1,0,0,1

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic preload();
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'(k); wdata = 32'(k) * 32'h0101;
      model[k] = 32'(k) * 32'h0101;
    end
    @(negedge clk);
    we = 1'b0;
    model[0] = 32'h0;
  endtask

  initial begin
    int n;
    int exp_idx;
    logic wrote;

    // 1: reset with a write pending
    rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF;
    raddr1 = 5'd6; raddr2 = 5'd7; dump_start = 1'b0; dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_valid", 32'(dump_valid), 32'h0);
    check("rst_done", 32'(dump_done), 32'h0);
    check("rst_idx", 32'(dump_idx), 32'h0);
    we = 1'b0; rst_n = 1'b1;
    for (int k = 1; k < 32; k++) begin
      raddr1 = 5'(k); #1;
      check($sformatf("rst_r%0d", k), rdata1, 32'h0);
    end
    raddr2 = 5'd5; #1;
    check("rst_r5_port2", rdata2, 32'h0);

    // 2: write then read, r0 write ignored
    wr(5'd5, 32'hDEAD_BEEF);
    raddr1 = 5'd5; #1;
    check("wr_r5", rdata1, 32'hDEAD_BEEF);
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'h0000_BABE; raddr2 = 5'd0; #1;
    check("wr_r0_fwd", rdata2, 32'h0);
    @(negedge clk);
    we = 1'b0; #1;
    check("wr_r0_stored", rdata2, 32'h0);

    // 3: forwarding on both ports in the write cycle
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h1111_BABE; raddr1 = 5'd9; raddr2 = 5'd9; #1;
    check("fwd_p1", rdata1, 32'h1111_BABE);
    check("fwd_p2", rdata2, 32'h1111_BABE);
    @(negedge clk);
    we = 1'b0; #1;
    check("fwd_stored", rdata1, 32'h1111_BABE);

    // 4: full dump with ready tied high
    preload();
    dump_ready = 1'b1; dump_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dump_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      check($sformatf("d4_valid%0d", i), 32'(dump_valid), 32'h1);
      check($sformatf("d4_idx%0d", i), 32'(dump_idx), 32'(i));
      check($sformatf("d4_data%0d", i), dump_data, 32'(i) * 32'h0101);
      @(negedge clk);
    end
    #1;
    check("d4_done", 32'(dump_done), 32'h1);
    check("d4_valid_end", 32'(dump_valid), 32'h0);
    @(negedge clk); #1;
    check("d4_done_pulse", 32'(dump_done), 32'h0);
    check("d4_idx_rst", 32'(dump_idx), 32'h0);

    // 5: backpressure with a write to r3 while word 1 is offered
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    exp_idx = 0; wrote = 1'b0; n = 0;
    while (n < 200) begin
      dump_ready = rdy_pat[n % 4];
      #1;
      if (!dump_valid) break;
      check("d5_idx", 32'(dump_idx), 32'(exp_idx));
      check("d5_data", dump_data, model[exp_idx]);
      if (exp_idx == 1 && !wrote) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D;
        model[3] = 32'hCAFE_F00D; wrote = 1'b1;
      end
      if (dump_ready) exp_idx++;
      @(negedge clk);
      we = 1'b0;
      n++;
    end
    check("d5_count", 32'(exp_idx), 32'd32);
    check("d5_done", 32'(dump_done), 32'h1);
    check("d5_r3", model[3], 32'hCAFE_F00D);

    // 6: reset in the middle of a dump
    dump_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    n = 0;
    while (dump_idx != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("d6_reach10", 32'(dump_idx), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    raddr1 = 5'd5;
    #1;
    check("d6_valid_async", 32'(dump_valid), 32'h0);
    check("d6_idx_async", 32'(dump_idx), 32'h0);
    check("d6_reg_clr", rdata1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("d6_no_words", 32'(dump_valid), 32'h0);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("d6_idx%0d", i), 32'(dump_idx), 32'(i));
      check($sformatf("d6_data%0d", i), dump_data, 32'h0);
      @(negedge clk);
    end
    n = 0;
    while (!dump_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("d6_done", 32'(dump_done), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
